uart_rx_fifo: RTL and testbench

Parametrised, synthesizable UART receiver with a runtime bit-rate divisor, configurable parity and a buffered output FIFO. It sits in the user project area on a `mprj_io` input pad (e.g. UART0 TX loop-back or an external host) and hands received characters to the Wishbone-side logic through a valid/ready interface. It supersedes fixed-rate, 8N1-only character capture and adds glitch rejection, per-character error tagging and overrun reporting.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_if.sv | 13 +
 rtl/uart_rx_fifo_sync_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receiver slice.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-side character stream: head-of-FIFO data and flags with valid/ready pop.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_perr_o;
    logic              rx_ferr_o;
    logic              rx_valid_o;
    logic              rx_ready_i;

    modport master (output rx_data_o, rx_perr_o, rx_ferr_o, rx_valid_o, input rx_ready_i);
    modport slave  (input rx_data_o, rx_perr_o, rx_ferr_o, rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; read data is zero while empty.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd];

    // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, mid-bit sampling FSM with runtime divisor and
// parity, feeding a tagged character FIFO with sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_en,
    output logic             overrun_o,
    input  logic             clr_overrun_i,
    output logic             busy_o,
    uart_rx_fifo_if.master   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        r_sync;
    logic              r_rx_prev;
    rx_state_t         r_state;
    logic [DIV_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_bit_idx;
    logic              r_perr;
    logic              r_overrun;

    logic              w_rx;
    logic              w_expire;
    logic              w_par_en;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W+1:0] w_wdata;
    logic [DATA_W+1:0] w_rdata;
    logic [CW-1:0]     w_count;

    assign w_rx     = r_sync[1];
    // <=1 rather than ==1 so a zero count left by an illegal divisor cannot stall.
    assign w_expire = (r_cnt <= DIV_W'(1));
    assign w_par_en = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
    assign w_push   = (r_state == ST_STOP) && w_expire && cfg_en;
    assign w_wdata  = {~w_rx, r_perr, r_shift};
    assign w_pop    = bus.rx_ready_i && !w_empty;
    assign busy_o   = (r_state != ST_IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_perr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx_i};
            r_rx_prev <= w_rx;
            if (!cfg_en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    // Arming needs a high-to-low edge, so a line held low after a
                    // break stays quiet until it has returned high.
                    ST_IDLE: if (r_rx_prev && !w_rx) begin
                        r_cnt   <= cfg_div >> 1;
                        r_state <= ST_START;
                    end
                    ST_START: if (!w_expire) r_cnt <= r_cnt - 1'b1;
                    else if (w_rx) r_state <= ST_IDLE;
                    else begin
                        r_cnt     <= cfg_div;
                        r_bit_idx <= '0;
                        r_perr    <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                    ST_DATA: if (!w_expire) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_cnt     <= cfg_div;
                        r_shift   <= {w_rx, r_shift[DATA_W-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 4'(DATA_W - 1))
                            r_state <= w_par_en ? ST_PARITY : ST_STOP;
                    end
                    ST_PARITY: if (!w_expire) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_cnt   <= cfg_div;
                        r_perr  <= ((^r_shift) ^ w_rx) != (cfg_parity == PAR_ODD);
                        r_state <= ST_STOP;
                    end
                    ST_STOP: if (!w_expire) r_cnt <= r_cnt - 1'b1;
                    else r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.rx_valid_o = (w_count != '0);
    assign {bus.rx_ferr_o, bus.rx_perr_o, bus.rx_data_o} = w_rdata;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                         r_overrun <= 1'b0;
        else if (w_push && w_full && !w_pop)  r_overrun <= 1'b1;
        else if (clr_overrun_i)               r_overrun <= 1'b0;
    end

    assign overrun_o = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8-bit and 7-bit instances driven with randomized frames,
// checked against a queue model of expected {ferr, perr, data} entries.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx8 = 1'b1;
    logic        rx7 = 1'b1;
    logic        en  = 1'b0;
    logic        clr8 = 1'b0;
    logic        clr7 = 1'b0;
    logic [15:0] div = 16'd16;
    logic [1:0]  par = PAR_NONE;
    logic        ovr8, ovr7, busy8, busy7;

    uart_rx_fifo_if #(.DATA_W(8)) bus8 ();
    uart_rx_fifo_if #(.DATA_W(7)) bus7 ();

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(8)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx8), .cfg_div(div), .cfg_parity(par),
        .cfg_en(en), .overrun_o(ovr8), .clr_overrun_i(clr8), .busy_o(busy8), .bus(bus8));

    uart_rx_fifo #(.DATA_W(7), .DIV_W(16), .FIFO_DEPTH(8)) u_dut7 (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx7), .cfg_div(div), .cfg_parity(par),
        .cfg_en(en), .overrun_o(ovr7), .clr_overrun_i(clr7), .busy_o(busy7), .bus(bus7));

    bit          sel = 1'b0;   // 0 selects the 8-bit instance, 1 the 7-bit one
    logic [9:0]  head;
    logic        hv;
    logic [9:0]  q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always_comb begin
        head = sel ? {bus7.rx_ferr_o, bus7.rx_perr_o, 1'b0, bus7.rx_data_o}
                   : {bus8.rx_ferr_o, bus8.rx_perr_o, bus8.rx_data_o};
        hv   = sel ? bus7.rx_valid_o : bus8.rx_valid_o;
    end

    task automatic set_rdy(input bit v);
        if (sel) bus7.rx_ready_i = v; else bus8.rx_ready_i = v;
    endtask

    task automatic set_line(input bit v);
        if (sel) rx7 = v; else rx8 = v;
    endtask

    function automatic int nbits();
        return sel ? 7 : 8;
    endfunction

    function automatic bit par_on();
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

    // Negedges from start-bit drive to first visible valid: 2 sync + div/2 to the
    // start mid-point + one div per later bit up to stop, + 1 registered push.
    function automatic int exp_lat();
        return 3 + int'(div) / 2 + (1 + nbits() + (par_on() ? 1 : 0)) * int'(div);
    endfunction

    function automatic logic [9:0] entry(input logic [7:0] d, input bit perr, input bit ferr);
        logic [7:0] dd;
        dd = sel ? {1'b0, d[6:0]} : d;
        return {ferr, perr, dd};
    endfunction

    // Drives one frame; reports where valid first rose and, if pop_at >= 0, pops there.
    task automatic send(input logic [7:0] d, input bit flip, input bit stop_v, input int pop_at,
                        output int vld_at, output logic [9:0] popped);
        bit   bits[$];
        bit   pb;
        bit   prev;
        int   k;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits(); i++) bits.push_back(d[i]);
        if (par_on()) begin
            pb = 1'b0;
            for (int i = 0; i < nbits(); i++) pb ^= d[i];
            if (par == PAR_ODD) pb = ~pb;
            bits.push_back(pb ^ flip);
        end
        bits.push_back(stop_v);
        for (int i = 0; i < 2 * int'(div) + 4; i++) bits.push_back(1'b1);
        vld_at = -1;
        popped = '0;
        prev   = hv;
        k      = 0;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < ((b <= nbits() + 1 + (par_on() ? 1 : 0)) ? int'(div) : 1); c++) begin
                @(negedge clk);
                if (hv && !prev && vld_at < 0) vld_at = k;
                prev = hv;
                if (k == pop_at) begin
                    popped = head;
                    set_rdy(1'b1);
                end else begin
                    set_rdy(1'b0);
                end
                set_line(bits[b]);
                k++;
            end
        end
    endtask

    // Back-to-back pops of everything the model holds, then an empty check.
    task automatic drain(input string tag);
        @(negedge clk);
        while (q.size() > 0) begin
            n_checks++;
            if (!hv || head !== q[0]) begin
                n_fail++;
                $display("FAIL %s: valid=%0b entry=%h required valid=1 entry=%h", tag, hv, head, q[0]);
            end
            void'(q.pop_front());
            set_rdy(1'b1);
            @(negedge clk);
        end
        set_rdy(1'b0);
        n_checks++;
        if (hv !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_empty: valid=%0b required 0", tag, hv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus8.rx_valid_o, bus8.rx_data_o, bus8.rx_perr_o, bus8.rx_ferr_o, ovr8, busy8} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset8: got %b required 0", {bus8.rx_valid_o, bus8.rx_data_o, bus8.rx_perr_o, bus8.rx_ferr_o, ovr8, busy8});
        end
        n_checks++;
        if ({bus7.rx_valid_o, bus7.rx_data_o, ovr7, busy7} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset7: got %b required 0", {bus7.rx_valid_o, bus7.rx_data_o, ovr7, busy7});
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        int         lat;
        logic [9:0] pw;
        logic [7:0] fixed [2];
        logic [7:0] d;
        bit         fl;
        sel = 1'b0; par = PAR_NONE; div = 16'd16;
        fixed[0] = 8'h41; fixed[1] = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            send(fixed[i], 1'b0, 1'b1, -1, lat, pw);
            n_checks++;
            if (lat != exp_lat()) begin
                n_fail++;
                $display("FAIL lat_8n1_%0d: valid at %0d required %0d", i, lat, exp_lat());
            end
            q.push_back(entry(fixed[i], 1'b0, 1'b0));
            drain("data_8n1");
        end
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            par = 2'($urandom_range(0, 3));
            div = 16'($urandom_range(4, 20));
            fl  = par_on() ? 1'($urandom) : 1'b0;
            send(d, fl, 1'b1, -1, lat, pw);
            n_checks++;
            if (lat != exp_lat()) begin
                n_fail++;
                $display("FAIL lat_rand_%0d: valid at %0d required %0d (div %0d par %0d)", i, lat, exp_lat(), div, par);
            end
            q.push_back(entry(d, fl, 1'b0));
            drain("rand_char");
        end
        par = PAR_NONE; div = 16'd16;
    endtask

    task automatic test_parity7();
        int         lat;
        logic [9:0] pw;
        logic [7:0] d;
        bit         fl;
        sel = 1'b1; par = PAR_EVEN; div = 16'd16;
        send(8'h55, 1'b0, 1'b1, -1, lat, pw);
        n_checks++;
        if (lat != exp_lat()) begin
            n_fail++;
            $display("FAIL lat_7e1: valid at %0d required %0d", lat, exp_lat());
        end
        q.push_back(entry(8'h55, 1'b0, 1'b0));
        send(8'h55, 1'b1, 1'b1, -1, lat, pw);
        q.push_back(entry(8'h55, 1'b1, 1'b0));
        drain("par7_fixed");
        for (int i = 0; i < 4; i++) begin
            d   = 8'($urandom);
            par = (i % 2 == 0) ? PAR_EVEN : PAR_ODD;
            fl  = 1'($urandom);
            send(d, fl, 1'b1, -1, lat, pw);
            q.push_back(entry(d, fl, 1'b0));
        end
        drain("par7_rand");
        sel = 1'b0; par = PAR_NONE;
    endtask

    task automatic test_break();
        int         rises;
        bit         prev;
        int         lat;
        logic [9:0] pw;
        sel = 1'b0; par = PAR_NONE; div = 16'd16;
        rises = 0;
        prev  = hv;
        for (int k = 0; k < 20 * 16; k++) begin
            @(negedge clk);
            if (hv && !prev) rises++;
            prev = hv;
            rx8 = 1'b0;
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (hv && !prev) rises++;
            prev = hv;
            rx8 = 1'b1;
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL break_rises: saw %0d valid rises required 1", rises);
        end
        q.push_back(entry(8'h00, 1'b0, 1'b1));
        drain("break");
        send(8'h3C, 1'b0, 1'b1, -1, lat, pw);
        q.push_back(entry(8'h3C, 1'b0, 1'b0));
        drain("after_break");
    endtask

    task automatic test_glitch();
        bit saw_busy;
        int back;
        sel = 1'b0; div = 16'd16;
        saw_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy8) saw_busy = 1'b1;
            rx8 = 1'b0;
        end
        @(negedge clk);
        if (busy8) saw_busy = 1'b1;
        rx8 = 1'b1;
        back = -1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (busy8) saw_busy = 1'b1;
            if (!busy8) begin
                back = j;
                break;
            end
        end
        n_checks++;
        if (!saw_busy || back < 0) begin
            n_fail++;
            $display("FAIL glitch_busy: seen_busy=%0b idle_after=%0d required seen_busy=1 idle within 8", saw_busy, back);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (hv !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_push: valid=%0b required 0", hv);
        end
    endtask

    task automatic test_overrun();
        int         lat;
        logic [9:0] pw;
        logic [7:0] d;
        sel = 1'b0; par = PAR_NONE; div = 16'd16;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send(d, 1'b0, 1'b1, -1, lat, pw);
            q.push_back(entry(d, 1'b0, 1'b0));
        end
        n_checks++;
        if (ovr8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_before_full: overrun=%0b required 0", ovr8);
        end
        send(8'($urandom), 1'b0, 1'b1, -1, lat, pw);
        n_checks++;
        if (ovr8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: overrun=%0b required 1", ovr8);
        end
        @(negedge clk); clr8 = 1'b1;
        @(negedge clk); clr8 = 1'b0;
        n_checks++;
        if (ovr8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: overrun=%0b required 0", ovr8);
        end
        // Pop lands on the same edge that samples the 10th character's stop bit.
        d = 8'($urandom);
        send(d, 1'b0, 1'b1, exp_lat() - 1, lat, pw);
        n_checks++;
        if (pw !== q[0]) begin
            n_fail++;
            $display("FAIL ovr_pop_head: popped %h required %h", pw, q[0]);
        end
        void'(q.pop_front());
        q.push_back(entry(d, 1'b0, 1'b0));
        n_checks++;
        if (ovr8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pop_push: overrun=%0b required 0", ovr8);
        end
        drain("ovr_order");
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [9:0] pw;
        logic [7:0] d;
        sel = 1'b0; par = PAR_NONE; div = 16'd16;
        send(8'h99, 1'b0, 1'b1, -1, lat, pw);
        d = 8'h5A;
        for (int k = 0; k < 4 * 16 + 8; k++) begin
            @(negedge clk);
            rx8 = (k < 16) ? 1'b0 : d[(k / 16) - 1];
        end
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1 || hv !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: busy=%0b valid=%0b required busy=1 valid=1", busy8, hv);
        end
        rst = 1'b1;
        rx8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus8.rx_valid_o, bus8.rx_data_o, bus8.rx_perr_o, bus8.rx_ferr_o, ovr8, busy8} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b required 0", {bus8.rx_valid_o, bus8.rx_data_o, bus8.rx_perr_o, bus8.rx_ferr_o, ovr8, busy8});
        end
        rst = 1'b0;
        q.delete();
        repeat (32) @(negedge clk);
        send(8'h7E, 1'b0, 1'b1, -1, lat, pw);
        n_checks++;
        if (lat != exp_lat()) begin
            n_fail++;
            $display("FAIL lat_after_reset: valid at %0d required %0d", lat, exp_lat());
        end
        q.push_back(entry(8'h7E, 1'b0, 1'b0));
        drain("after_reset");
    endtask

    initial begin
        bus8.rx_ready_i = 1'b0;
        bus7.rx_ready_i = 1'b0;
        test_reset();
        test_8n1();
        test_parity7();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
